ps2_key_event_ctrl: RTL and testbench

//  Sequences the byte stream from the PS/2 frame receiver into game key events.

---
 rtl/ps2_key_event_ctrl_if.sv | 21 ++
 rtl/ps2_key_event_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_event_ctrl_if.sv
// Byte-in / event-out handshake bundle for ps2_key_event_ctrl.
// master: the side that supplies scan bytes and consumes events.
// slave : the key event controller itself.
interface ps2_key_event_ctrl_if;
    logic       code_valid;
    logic [7:0] code;
    logic       code_err;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] ev_data;

    modport master (
        output code_valid, code, code_err, ev_ready,
        input  ev_valid, ev_data
    );

    modport slave (
        input  code_valid, code, code_err, ev_ready,
        output ev_valid, ev_data
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// Turns the PS/2 scan byte stream (make / F0 break / E0 extended prefixes)
// into make/break events for 7 game keys. It also keeps a held-key bitmap and
// queues the events in a small FIFO with a valid/ready pop port.
// A pending prefix is abandoned after TIMEOUT_CYC cycles with no byte.
// Optional feature: define PS2_REPEAT_FILTER_EN to suppress typematic repeat
// makes, which are makes for a key that is already held.
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    ps2_key_event_ctrl_if.slave      bus,
    input  logic                     clear_ovf_i,
    output logic                     ev_overflow_o,
    output logic [6:0]               key_down_o,
    output logic [1:0]               state_dbg_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        EXT     = 2'b01,
        BRK     = 2'b10,
        EXT_BRK = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [6:0]         key_q, key_d;
    logic [3:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ev_valid_q, ev_valid_d;
    logic [3:0]         ev_data_q, ev_data_d;
    logic               ovf_q, ovf_d;

    logic [3:0]         lk_s;
    logic               ev_make_s;
    logic               ev_hit_s;
    logic [2:0]         ev_idx_s;
    logic [3:0]         ev_code_s;
    logic               push_req_s, push_s, pop_s, full_s;

    // Scan code to key index; result is {hit, idx[2:0]}.
    function automatic logic [3:0] key_lookup(input logic ext, input logic [7:0] c);
        logic [3:0] r;
        r = 4'h0;
        if (ext) begin
            case (c)
                8'h75:   r = 4'b1000;
                8'h72:   r = 4'b1001;
                8'h6B:   r = 4'b1010;
                8'h74:   r = 4'b1011;
                default: r = 4'b0000;
            endcase
        end else begin
            case (c)
                8'h29:   r = 4'b1100;
                8'h5A:   r = 4'b1101;
                8'h76:   r = 4'b1110;
                default: r = 4'b0000;
            endcase
        end
        return r;
    endfunction

    // Prefix FSM next state, key lookup and prefix timeout counter.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        lk_s      = 4'h0;
        ev_make_s = 1'b0;
        if (bus.code_valid) begin
            to_cnt_d = {TO_W{1'b0}};
            if (bus.code_err) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.code == CODE_EXT) begin
                            state_d = EXT;
                        end else if (bus.code == CODE_BRK) begin
                            state_d = BRK;
                        end else begin
                            lk_s      = key_lookup(1'b0, bus.code);
                            ev_make_s = 1'b1;
                        end
                    end
                    EXT: begin
                        if (bus.code == CODE_BRK) begin
                            state_d = EXT_BRK;
                        end else if (bus.code == CODE_EXT) begin
                            state_d = EXT;
                        end else begin
                            lk_s      = key_lookup(1'b1, bus.code);
                            ev_make_s = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                    BRK: begin
                        state_d = IDLE;
                        if (bus.code != CODE_EXT && bus.code != CODE_BRK) begin
                            lk_s = key_lookup(1'b0, bus.code);
                        end else begin
                            lk_s = 4'h0;
                        end
                    end
                    EXT_BRK: begin
                        state_d = IDLE;
                        if (bus.code != CODE_EXT && bus.code != CODE_BRK) begin
                            lk_s = key_lookup(1'b1, bus.code);
                        end else begin
                            lk_s = 4'h0;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q == IDLE) begin
            to_cnt_d = {TO_W{1'b0}};
        end else if (to_cnt_q == TO_LAST) begin
            state_d  = IDLE;
            to_cnt_d = {TO_W{1'b0}};
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Event decode, bitmap update and push request (repeat filter is optional).
    always_comb begin
        ev_hit_s  = lk_s[3];
        ev_idx_s  = lk_s[2:0];
        ev_code_s = {ev_make_s, lk_s[2:0]};
        key_d     = key_q;
        if (ev_hit_s) begin
            key_d[ev_idx_s] = ev_make_s;
        end else begin
            key_d = key_q;
        end
`ifdef PS2_REPEAT_FILTER_EN
        push_req_s = ev_hit_s && !(ev_make_s && key_q[ev_idx_s]);
`else
        push_req_s = ev_hit_s;
`endif
    end

    // FIFO pointers, occupancy, overflow flag and registered head output.
    always_comb begin
        pop_s    = ev_valid_q & bus.ev_ready;
        full_s   = (count_q == CNT_FULL);
        push_s   = push_req_s & (~full_s | pop_s);
        rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_req_s && full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else if (clear_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        ev_valid_d = (count_d != {CNT_W{1'b0}});
        // The new head is the entry being written when the write slot is the read slot.
        if (count_d == {CNT_W{1'b0}}) begin
            ev_data_d = 4'h0;
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            ev_data_d = ev_code_s;
        end else begin
            ev_data_d = mem_q[rd_ptr_d];
        end
    end

    // State, counter, bitmap and FIFO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            to_cnt_q   <= {TO_W{1'b0}};
            key_q      <= 7'b0000000;
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            ev_valid_q <= 1'b0;
            ev_data_q  <= 4'h0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 4'h0;
            end
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            key_q      <= key_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ev_valid_q <= ev_valid_d;
            ev_data_q  <= ev_data_d;
            ovf_q      <= ovf_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= ev_code_s;
            end
        end
    end

    assign bus.ev_valid  = ev_valid_q;
    assign bus.ev_data   = ev_data_q;
    assign ev_overflow_o = ovf_q;
    assign key_down_o    = key_q;
    assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed self-checking bench for ps2_key_event_ctrl (FIFO_DEPTH=4, TIMEOUT_CYC=20).
module tb_ps2_key_event_ctrl;
    localparam int TO = 20;

    logic       clk;
    logic       rst;
    logic       clear_ovf;
    logic       ev_overflow;
    logic [6:0] key_down;
    logic [1:0] state_dbg;
    int         errors;
    int         checks;

    ps2_key_event_ctrl_if bus ();

    ps2_key_event_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .clear_ovf_i   (clear_ovf),
        .ev_overflow_o (ev_overflow),
        .key_down_o    (key_down),
        .state_dbg_o   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tasks start and end just after a falling edge.
    task automatic send_code(input logic [7:0] c, input logic err);
        bus.code_valid = 1'b1;
        bus.code       = c;
        bus.code_err   = err;
        @(negedge clk);
        bus.code_valid = 1'b0;
        bus.code_err   = 1'b0;
        bus.code       = 8'h00;
    endtask

    task automatic pop_one();
        bus.ev_ready = 1'b1;
        @(negedge clk);
        bus.ev_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (state_dbg !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", state_dbg); end
        checks++; if (bus.ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got=%b exp=0", bus.ev_valid); end
        checks++; if (bus.ev_data !== 4'h0) begin errors++; $display("FAIL reset_ev_data got=%h exp=0", bus.ev_data); end
        checks++; if (key_down !== 7'b0000000) begin errors++; $display("FAIL reset_key_down got=%b exp=0000000", key_down); end
        checks++; if (ev_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ev_overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_make();
        send_code(8'h29, 1'b0);
        checks++; if (key_down !== 7'b0010000) begin errors++; $display("FAIL t1_key_down got=%b exp=0010000", key_down); end
        checks++; if (bus.ev_valid !== 1'b1) begin errors++; $display("FAIL t1_ev_valid got=%b exp=1", bus.ev_valid); end
        checks++; if (bus.ev_data !== 4'hC) begin errors++; $display("FAIL t1_ev_data got=%h exp=C", bus.ev_data); end
        pop_one();
        checks++; if (bus.ev_valid !== 1'b0) begin errors++; $display("FAIL t1_popped_valid got=%b exp=0", bus.ev_valid); end
        checks++; if (bus.ev_data !== 4'h0) begin errors++; $display("FAIL t1_popped_data got=%h exp=0", bus.ev_data); end
    endtask

    task automatic test_extended();
        send_code(8'hE0, 1'b0);
        checks++; if (state_dbg !== 2'b01) begin errors++; $display("FAIL t2_state_ext got=%b exp=01", state_dbg); end
        send_code(8'h75, 1'b0);
        checks++; if (state_dbg !== 2'b00) begin errors++; $display("FAIL t2_state_idle got=%b exp=00", state_dbg); end
        checks++; if (bus.ev_data !== 4'h8) begin errors++; $display("FAIL t2_make_data got=%h exp=8", bus.ev_data); end
        checks++; if (key_down !== 7'b0000001) begin errors++; $display("FAIL t2_key_set got=%b exp=0000001", key_down); end
        pop_one();
        send_code(8'hE0, 1'b0);
        send_code(8'hF0, 1'b0);
        checks++; if (state_dbg !== 2'b11) begin errors++; $display("FAIL t2_state_extbrk got=%b exp=11", state_dbg); end
        send_code(8'h75, 1'b0);
        checks++; if (bus.ev_valid !== 1'b1) begin errors++; $display("FAIL t2_brk_valid got=%b exp=1", bus.ev_valid); end
        checks++; if (bus.ev_data !== 4'h0) begin errors++; $display("FAIL t2_brk_data got=%h exp=0", bus.ev_data); end
        checks++; if (key_down !== 7'b0000000) begin errors++; $display("FAIL t2_key_clr got=%b exp=0000000", key_down); end
        pop_one();
    endtask

    task automatic test_timeout();
        send_code(8'hE0, 1'b0);
        repeat (TO - 1) @(negedge clk);
        checks++; if (state_dbg !== 2'b01) begin errors++; $display("FAIL t3_before_timeout got=%b exp=01", state_dbg); end
        @(negedge clk);
        checks++; if (state_dbg !== 2'b00) begin errors++; $display("FAIL t3_after_timeout got=%b exp=00", state_dbg); end
        send_code(8'h75, 1'b0);
        checks++; if (bus.ev_valid !== 1'b0) begin errors++; $display("FAIL t3_no_event got=%b exp=0", bus.ev_valid); end
        checks++; if (key_down !== 7'b0000000) begin errors++; $display("FAIL t3_key_down got=%b exp=0000000", key_down); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_q [4];
        exp_q[0] = 4'hD; exp_q[1] = 4'hE; exp_q[2] = 4'h4; exp_q[3] = 4'h4;
        send_code(8'h29, 1'b0);
        send_code(8'h5A, 1'b0);
        send_code(8'h76, 1'b0);
        send_code(8'hF0, 1'b0);
        send_code(8'h29, 1'b0);
        checks++; if (ev_overflow !== 1'b0) begin errors++; $display("FAIL t4_ovf_at_full got=%b exp=0", ev_overflow); end
        send_code(8'h29, 1'b0);
        checks++; if (ev_overflow !== 1'b1) begin errors++; $display("FAIL t4_ovf_set got=%b exp=1", ev_overflow); end
        checks++; if (key_down !== 7'b1110000) begin errors++; $display("FAIL t4_key_down got=%b exp=1110000", key_down); end
        checks++; if (bus.ev_data !== 4'hC) begin errors++; $display("FAIL t4_head got=%h exp=C", bus.ev_data); end
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        checks++; if (ev_overflow !== 1'b0) begin errors++; $display("FAIL t4_ovf_clear got=%b exp=0", ev_overflow); end
        // Push into a full FIFO while popping: both happen, no overflow.
        send_code(8'hF0, 1'b0);
        bus.ev_ready = 1'b1;
        send_code(8'h29, 1'b0);
        bus.ev_ready = 1'b0;
        checks++; if (ev_overflow !== 1'b0) begin errors++; $display("FAIL t4_full_pop_ovf got=%b exp=0", ev_overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.ev_valid !== 1'b1) begin errors++; $display("FAIL t4_drain_valid[%0d] got=%b exp=1", i, bus.ev_valid); end
            checks++; if (bus.ev_data !== exp_q[i]) begin errors++; $display("FAIL t4_drain_data[%0d] got=%h exp=%h", i, bus.ev_data, exp_q[i]); end
            pop_one();
        end
        checks++; if (bus.ev_valid !== 1'b0) begin errors++; $display("FAIL t4_drained got=%b exp=0", bus.ev_valid); end
    endtask

    task automatic test_code_err();
        send_code(8'hE0, 1'b0);
        send_code(8'h72, 1'b1);
        checks++; if (state_dbg !== 2'b00) begin errors++; $display("FAIL t5_state_after_err got=%b exp=00", state_dbg); end
        checks++; if (bus.ev_valid !== 1'b0) begin errors++; $display("FAIL t5_err_no_event got=%b exp=0", bus.ev_valid); end
        send_code(8'h72, 1'b0);
        checks++; if (bus.ev_valid !== 1'b0) begin errors++; $display("FAIL t5_unmapped_no_event got=%b exp=0", bus.ev_valid); end
        checks++; if (key_down !== 7'b0000000) begin errors++; $display("FAIL t5_key_down got=%b exp=0000000", key_down); end
    endtask

    task automatic test_repeat();
        int n;
        int exp_n;
`ifdef PS2_REPEAT_FILTER_EN
        exp_n = 1;
`else
        exp_n = 2;
`endif
        send_code(8'h29, 1'b0);
        send_code(8'h29, 1'b0);
        checks++; if (key_down !== 7'b0010000) begin errors++; $display("FAIL t6_key_down got=%b exp=0010000", key_down); end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.ev_valid === 1'b1) begin
                n++;
                pop_one();
            end
        end
        checks++; if (n !== exp_n) begin errors++; $display("FAIL t6_event_count got=%0d exp=%0d", n, exp_n); end
    endtask

    task automatic test_back_to_back();
        send_code(8'hE0, 1'b0);
        send_code(8'h74, 1'b0);
        send_code(8'h5A, 1'b0);
        checks++; if (key_down !== 7'b0101000) begin errors++; $display("FAIL b2b_key_down got=%b exp=0101000", key_down); end
        checks++; if (bus.ev_data !== 4'hB) begin errors++; $display("FAIL b2b_first got=%h exp=B", bus.ev_data); end
        pop_one();
        checks++; if (bus.ev_data !== 4'hD) begin errors++; $display("FAIL b2b_second got=%h exp=D", bus.ev_data); end
        pop_one();
        checks++; if (bus.ev_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", bus.ev_valid); end
    endtask

    task automatic test_mid_reset();
        send_code(8'h29, 1'b0);
        send_code(8'hE0, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (state_dbg !== 2'b00) begin errors++; $display("FAIL mr_state got=%b exp=00", state_dbg); end
        checks++; if (bus.ev_valid !== 1'b0) begin errors++; $display("FAIL mr_ev_valid got=%b exp=0", bus.ev_valid); end
        checks++; if (key_down !== 7'b0000000) begin errors++; $display("FAIL mr_key_down got=%b exp=0000000", key_down); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        clear_ovf = 1'b0;
        bus.code_valid = 1'b0;
        bus.code = 8'h00;
        bus.code_err = 1'b0;
        bus.ev_ready = 1'b0;
        test_reset();
        test_single_make();   do_reset();
        test_extended();      do_reset();
        test_timeout();       do_reset();
        test_overflow();      do_reset();
        test_code_err();      do_reset();
        test_repeat();        do_reset();
        test_back_to_back();  do_reset();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
